// File: rtl/level_round_sequencer.sv
`default_nettype none
// ============================================================================
// level_round_sequencer: one guessing level - show target, take guesses,
// judge them, and report level done / level fail.      Revision: 1.0
// ============================================================================
module level_round_sequencer #(
  parameter int NUM_ROUNDS     = 4,
  parameter int MAX_WRONG      = 3,
  parameter int SYM_W          = 3,
  parameter int SHOW_CYCLES    = 50000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             levelStart,
  input  logic             guess_valid,
  input  logic [SYM_W-1:0] guess_data,
  output logic             guess_ready,
  output logic [SYM_W-1:0] target,
  output logic             showTarget,
  output logic [2:0]       roundNum,
  output logic [2:0]       guesses,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic             levelDone,
  output logic             levelFail
);

  localparam int TMR_MAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [2:0]       ROUNDS_C  = 3'(NUM_ROUNDS);
  localparam logic [2:0]       WRONG_C   = 3'(MAX_WRONG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHOW  = 3'd1,
    S_WAIT  = 3'd2,
    S_JUDGE = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SYM_W-1:0] target_q, target_d;
  logic [2:0]       round_q, round_d;
  logic [2:0]       wrong_q, wrong_d;
  logic             match_q, match_d;
  logic [2:0]       round_inc;
  logic [2:0]       wrong_inc;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 8'h01;
      timer_q  <= '0;
      target_q <= '0;
      round_q  <= 3'd0;
      wrong_q  <= 3'd0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      target_q <= target_d;
      round_q  <= round_d;
      wrong_q  <= wrong_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    // Fibonacci x^8+x^6+x^5+x^4+1, free-running
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    state_d   = state_q;
    timer_d   = timer_q;
    target_d  = target_q;
    round_d   = round_q;
    wrong_d   = wrong_q;
    match_d   = match_q;
    round_inc = round_q + 3'd1;
    wrong_inc = wrong_q + 3'd1;

    if (state_q != S_IDLE && !levelStart) begin
      // abort: counters clear and no judgement is made
      state_d  = S_IDLE;
      timer_d  = '0;
      target_d = '0;
      round_d  = 3'd0;
      wrong_d  = 3'd0;
      match_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d  = '0;
          target_d = '0;
          round_d  = 3'd0;
          wrong_d  = 3'd0;
          match_d  = 1'b0;
          if (levelStart) begin
            state_d  = S_SHOW;
            target_d = lfsr_q[SYM_W-1:0];
          end
        end
        S_SHOW: begin
          if (timer_q == SHOW_LAST) begin
            state_d = S_WAIT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        S_WAIT: begin
          // an accepted guess takes priority over an expiring timeout
          if (guess_valid) begin
            match_d = (guess_data == target_q);
            state_d = S_JUDGE;
            timer_d = '0;
          end else if (timer_q == WAIT_LAST) begin
            match_d = 1'b0;
            state_d = S_JUDGE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        S_JUDGE: begin
          if (match_q) begin
            round_d = round_inc;
            if (round_inc == ROUNDS_C) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_SHOW;
              target_d = lfsr_q[SYM_W-1:0];
            end
          end else begin
            wrong_d = wrong_inc;
            state_d = (wrong_inc == WRONG_C) ? S_FAIL : S_SHOW;
          end
        end
        S_DONE:  state_d = S_DONE;
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign guess_ready = (state_q == S_WAIT);
  assign showTarget  = (state_q == S_SHOW);
  assign hit_pulse   = (state_q == S_JUDGE) &&  match_q;
  assign miss_pulse  = (state_q == S_JUDGE) && !match_q;
  assign levelDone   = (state_q == S_DONE);
  assign levelFail   = (state_q == S_FAIL);
  assign target      = target_q;
  assign roundNum    = round_q;
  assign guesses     = wrong_q;

endmodule
`default_nettype wire

// File: tb/tb_level_round_sequencer.sv
`default_nettype none
// ============================================================================
// tb_level_round_sequencer: directed bench for level_round_sequencer.
// Revision: 1.0
// ============================================================================
module tb_level_round_sequencer;
  localparam int NR = 2;
  localparam int MW = 3;
  localparam int SW = 3;
  localparam int SC = 4;
  localparam int TC = 8;

  logic          Clk;
  logic          reset;
  logic          levelStart;
  logic          guess_valid;
  logic [SW-1:0] guess_data;
  logic          guess_ready;
  logic [SW-1:0] target;
  logic          showTarget;
  logic [2:0]    roundNum;
  logic [2:0]    guesses;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          levelDone;
  logic          levelFail;

  logic [7:0]    m_lfsr;
  logic [SW-1:0] exp_t;
  int            checks = 0;
  int            errors = 0;
  int            n;

  level_round_sequencer #(
    .NUM_ROUNDS(NR), .MAX_WRONG(MW), .SYM_W(SW), .SHOW_CYCLES(SC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .Clk(Clk), .reset(reset), .levelStart(levelStart), .guess_valid(guess_valid),
    .guess_data(guess_data), .guess_ready(guess_ready), .target(target),
    .showTarget(showTarget), .roundNum(roundNum), .guesses(guesses),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .levelDone(levelDone),
    .levelFail(levelFail)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // reference sequence generator for target prediction
  always @(posedge Clk or negedge reset) begin
    if (!reset) m_lfsr <= 8'h01;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic wait_show(output int cnt);
    cnt = 0;
    while (showTarget === 1'b1 && cnt < 20) begin cnt++; tick(); end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (guess_ready === 1'b1 && cnt < 20) begin cnt++; tick(); end
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    reset = 1'b0; levelStart = 1'b0; guess_valid = 1'b0; guess_data = '0;
    repeat (2) @(negedge Clk);
    outs = {guess_ready, showTarget, hit_pulse, miss_pulse, levelDone, levelFail, target, roundNum, guesses};
    checks++; if (outs !== 16'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0000", outs); end
    reset = 1'b1; levelStart = 1'b1;
    tick();
    checks++; if (target !== 3'd1) begin errors++; $display("FAIL first_target: got %0d expected 1", target); end
    checks++; if (showTarget !== 1'b1) begin errors++; $display("FAIL first_show: got %b expected 1", showTarget); end
    wait_show(n);
    tick(); tick();
    checks++; if (guess_ready !== 1'b1) begin errors++; $display("FAIL pre_reset_wait: got %b expected 1", guess_ready); end
    #2 reset = 1'b0;
    #1;
    outs = {guess_ready, showTarget, hit_pulse, miss_pulse, levelDone, levelFail, target, roundNum, guesses};
    checks++; if (outs !== 16'h0) begin errors++; $display("FAIL async_reset: got %h expected 0000", outs); end
    levelStart = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    tick();
    outs = {guess_ready, showTarget, hit_pulse, miss_pulse, levelDone, levelFail, target, roundNum, guesses};
    checks++; if (outs !== 16'h0) begin errors++; $display("FAIL idle_after_release: got %h expected 0000", outs); end
  endtask

  task automatic test_win();
    levelStart = 1'b1; exp_t = m_lfsr[SW-1:0];
    tick();
    for (int r = 0; r < NR; r++) begin
      checks++; if (target !== exp_t) begin errors++; $display("FAIL win_target r%0d: got %0d expected %0d", r, target, exp_t); end
      checks++; if (roundNum !== 3'(r)) begin errors++; $display("FAIL win_round r%0d: got %0d expected %0d", r, roundNum, r); end
      wait_show(n);
      checks++; if (n != SC) begin errors++; $display("FAIL win_show_len r%0d: got %0d expected %0d", r, n, SC); end
      checks++; if (guess_ready !== 1'b1) begin errors++; $display("FAIL win_ready r%0d: got %b expected 1", r, guess_ready); end
      guess_valid = 1'b1; guess_data = exp_t;
      tick();
      guess_valid = 1'b0;
      checks++; if ({hit_pulse, miss_pulse} !== 2'b10) begin errors++; $display("FAIL win_hit r%0d: got %b expected 10", r, {hit_pulse, miss_pulse}); end
      exp_t = m_lfsr[SW-1:0];
      tick();
    end
    checks++; if (levelDone !== 1'b1) begin errors++; $display("FAIL win_done: got %b expected 1", levelDone); end
    checks++; if (roundNum !== 3'd2 || guesses !== 3'd0) begin errors++; $display("FAIL win_counts: got r%0d g%0d expected r2 g0", roundNum, guesses); end
    checks++; if (showTarget !== 1'b0 || guess_ready !== 1'b0) begin errors++; $display("FAIL win_quiet: got show %b ready %b expected 0 0", showTarget, guess_ready); end
  endtask

  task automatic test_fail();
    levelStart = 1'b0;
    tick();
    checks++; if (levelDone !== 1'b0 || roundNum !== 3'd0) begin errors++; $display("FAIL done_exit: got done %b r%0d expected 0 r0", levelDone, roundNum); end
    levelStart = 1'b1; exp_t = m_lfsr[SW-1:0];
    tick();
    for (int i = 0; i < MW; i++) begin
      checks++; if (target !== exp_t) begin errors++; $display("FAIL fail_replay_target i%0d: got %0d expected %0d", i, target, exp_t); end
      wait_show(n);
      guess_valid = 1'b1; guess_data = exp_t ^ 3'b001;
      tick();
      guess_valid = 1'b0;
      checks++; if ({hit_pulse, miss_pulse} !== 2'b01) begin errors++; $display("FAIL fail_miss i%0d: got %b expected 01", i, {hit_pulse, miss_pulse}); end
      tick();
      checks++; if (guesses !== 3'(i + 1)) begin errors++; $display("FAIL fail_count i%0d: got %0d expected %0d", i, guesses, i + 1); end
    end
    checks++; if (levelFail !== 1'b1 || showTarget !== 1'b0) begin errors++; $display("FAIL fail_flag: got fail %b show %b expected 1 0", levelFail, showTarget); end
    guess_valid = 1'b1; guess_data = exp_t;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (guess_ready !== 1'b0 || levelFail !== 1'b1 || guesses !== 3'd3) begin
        errors++; $display("FAIL fail_hold k%0d: got ready %b fail %b g%0d expected 0 1 g3", k, guess_ready, levelFail, guesses);
      end
    end
    guess_valid = 1'b0;
  endtask

  task automatic test_timeout();
    levelStart = 1'b0;
    tick();
    checks++; if (levelFail !== 1'b0 || guesses !== 3'd0) begin errors++; $display("FAIL fail_exit: got fail %b g%0d expected 0 g0", levelFail, guesses); end
    levelStart = 1'b1; exp_t = m_lfsr[SW-1:0];
    tick();
    wait_show(n);
    wait_ready(n);
    checks++; if (n != TC) begin errors++; $display("FAIL timeout_wait_len: got %0d expected %0d", n, TC); end
    checks++; if ({hit_pulse, miss_pulse} !== 2'b01) begin errors++; $display("FAIL timeout_miss: got %b expected 01", {hit_pulse, miss_pulse}); end
    tick();
    checks++; if (guesses !== 3'd1 || showTarget !== 1'b1) begin errors++; $display("FAIL timeout_replay: got g%0d show %b expected g1 1", guesses, showTarget); end
    checks++; if (target !== exp_t) begin errors++; $display("FAIL timeout_target: got %0d expected %0d", target, exp_t); end
  endtask

  task automatic test_simultaneous();
    wait_show(n);
    repeat (TC - 1) tick();
    checks++; if (guess_ready !== 1'b1) begin errors++; $display("FAIL simul_last_wait: got %b expected 1", guess_ready); end
    guess_valid = 1'b1; guess_data = exp_t;
    tick();
    guess_valid = 1'b0;
    checks++; if ({hit_pulse, miss_pulse} !== 2'b10) begin errors++; $display("FAIL simul_hit: got %b expected 10", {hit_pulse, miss_pulse}); end
    tick();
    checks++; if (guesses !== 3'd1 || roundNum !== 3'd1 || showTarget !== 1'b1) begin
      errors++; $display("FAIL simul_counts: got g%0d r%0d show %b expected g1 r1 1", guesses, roundNum, showTarget);
    end
  endtask

  task automatic test_abort();
    tick();
    levelStart = 1'b0;
    tick();
    checks++; if (showTarget !== 1'b0 || roundNum !== 3'd0 || guesses !== 3'd0) begin
      errors++; $display("FAIL abort_clear: got show %b r%0d g%0d expected 0 r0 g0", showTarget, roundNum, guesses);
    end
    checks++; if ({guess_ready, hit_pulse, miss_pulse} !== 3'b000) begin errors++; $display("FAIL abort_quiet: got %b expected 000", {guess_ready, hit_pulse, miss_pulse}); end
    levelStart = 1'b1; exp_t = m_lfsr[SW-1:0];
    tick();
    checks++; if (showTarget !== 1'b1 || roundNum !== 3'd0) begin errors++; $display("FAIL relaunch: got show %b r%0d expected 1 r0", showTarget, roundNum); end
    checks++; if (target !== exp_t) begin errors++; $display("FAIL relaunch_target: got %0d expected %0d", target, exp_t); end
    levelStart = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_win();
    test_fail();
    test_timeout();
    test_simultaneous();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
